// File: rtl/ram_frame_reader_pkg.sv
// rtl/ram_frame_reader_pkg.sv - shared constants, FSM encoding and parameter checks for ram_frame_reader
package ram_frame_reader_pkg;

  localparam int DATA_W          = 32;
  localparam int MAX_RAM_LATENCY = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_READ  = ST_READ,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_t;

  function automatic bit frame_len_ok(input int frame_len, input int addr_w);
    return (frame_len >= 1) && (frame_len <= (1 << addr_w));
  endfunction

  function automatic bit ram_latency_ok(input int ram_latency);
    return (ram_latency >= 1) && (ram_latency <= MAX_RAM_LATENCY);
  endfunction

endpackage

// File: rtl/ram_frame_reader_if.sv
// rtl/ram_frame_reader_if.sv - RAM read port and output word stream of ram_frame_reader
interface ram_frame_reader_if #(
  parameter int ADDR_W = 6
);
  import ram_frame_reader_pkg::*;

  logic              o_ram_rd_en;
  logic [ADDR_W-1:0] o_ram_rd_addr;
  logic [DATA_W-1:0] i_ram_rd_data;
  logic              o_data_valid;
  logic [DATA_W-1:0] o_data;

  modport master (
    output o_ram_rd_en,
    output o_ram_rd_addr,
    input  i_ram_rd_data,
    output o_data_valid,
    output o_data
  );

  modport slave (
    input  o_ram_rd_en,
    input  o_ram_rd_addr,
    output i_ram_rd_data,
    input  o_data_valid,
    input  o_data
  );

endinterface

// File: rtl/ram_frame_reader_rd_latency_pipe.sv
// rtl/ram_frame_reader_rd_latency_pipe.sv - valid shift register matching a RAM read latency
module rd_latency_pipe #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  output logic o_valid
);

  logic [DEPTH-1:0] r_pipe;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_pipe <= '0;
        else       r_pipe <= i_valid;
      end
    end else begin : g_shift
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_pipe <= '0;
        else       r_pipe <= {r_pipe[DEPTH-2:0], i_valid};
      end
    end
  endgenerate

  assign o_valid = r_pipe[DEPTH-1];

endmodule

// File: rtl/ram_frame_reader.sv
// rtl/ram_frame_reader.sv - streams one stored frame out of synchronous RAM as a contiguous valid-qualified word run
module ram_frame_reader
  import ram_frame_reader_pkg::*;
#(
  parameter int FRAME_LEN   = 64,
  parameter int ADDR_W      = 6,
  parameter int BASE_ADDR   = 0,
  parameter int RAM_LATENCY = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  ram_frame_reader_if.master bus,
  output logic               o_busy,
  output logic               o_read_done
);

  generate
    if (!frame_len_ok(FRAME_LEN, ADDR_W)) begin : g_bad_frame_len
      $error("ram_frame_reader: FRAME_LEN must lie in 1..2**ADDR_W");
    end
    if (!ram_latency_ok(RAM_LATENCY)) begin : g_bad_ram_latency
      $error("ram_frame_reader: RAM_LATENCY must lie in 1..4");
    end
  endgenerate

  localparam logic [ADDR_W:0]   LAST_IDX   = (ADDR_W+1)'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [2:0]        DRAIN_LAST = 3'(RAM_LATENCY);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W:0]   r_index;
  logic [2:0]        r_drain_cnt;
  logic              w_rd_en;
  logic              w_pipe_tail;
  logic              r_data_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_READ;
      S_READ:  if (r_index == LAST_IDX) w_state_next = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Drain spans RAM_LATENCY+1 cycles so the final word reaches o_data before DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_index     <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_index     <= (r_state == S_READ)  ? r_index + 1'b1     : '0;
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
    end
  end

  assign w_rd_en           = (r_state == S_READ);
  assign bus.o_ram_rd_en   = w_rd_en;
  assign bus.o_ram_rd_addr = w_rd_en ? BASE + r_index[ADDR_W-1:0] : '0;

  rd_latency_pipe #(
    .DEPTH (RAM_LATENCY)
  ) u_rd_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_rd_en),
    .o_valid (w_pipe_tail)
  );

  // o_data is only loaded on a live RAM word, so it holds between frames.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_valid <= 1'b0;
      r_data       <= '0;
    end else begin
      r_data_valid <= w_pipe_tail;
      if (w_pipe_tail) r_data <= bus.i_ram_rd_data;
    end
  end

  assign bus.o_data_valid = r_data_valid;
  assign bus.o_data       = r_data;
  assign o_busy           = (r_state != S_IDLE);
  assign o_read_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_ram_frame_reader.sv
// tb/tb_ram_frame_reader.sv - scoreboard bench for ram_frame_reader over three parameter sets
`timescale 1ns/1ps
module tb_ram_frame_reader;

  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int NCFG  = 3;
  localparam int NONE  = -100000;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  int   checks = 0;
  int   errors = 0;
  event reseed;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int FL = (g == 0) ? 64 : (g == 1) ? 8 : 1;
    localparam int LT = (g == 0) ? 1  : (g == 1) ? 3 : 2;
    localparam int BA = (g == 0) ? 0  : (g == 1) ? 60 : 5;

    ram_frame_reader_if #(.ADDR_W(AW)) u_bus ();
    logic        busy;
    logic        done;
    logic [31:0] mem [DEPTH];
    logic [31:0] rq  [4];

    ram_frame_reader #(
      .FRAME_LEN   (FL),
      .ADDR_W      (AW),
      .BASE_ADDR   (BA),
      .RAM_LATENCY (LT)
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .bus         (u_bus),
      .o_busy      (busy),
      .o_read_done (done)
    );

    initial begin
      for (int a = 0; a < DEPTH; a++) mem[a] = (g == 0) ? 32'hA000 + a : $urandom;
      forever begin
        @(reseed);
        for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
      end
    end

    // RAM with LT-cycle read latency
    always @(posedge clk) begin
      rq[0] <= mem[u_bus.o_ram_rd_addr];
      for (int s = 1; s < 4; s++) rq[s] <= rq[s-1];
    end
    assign u_bus.i_ram_rd_data = rq[LT-1];

    // Reference timeline: a frame accepted at edge k owns cycles k+1 .. k+FL+LT+2.
    int          e    = 0;
    int          k    = NONE;
    logic [31:0] exp_q [$];
    logic [31:0] last = '0;

    always @(posedge clk) begin
      int          rel;
      logic [31:0] w;
      e++;
      if (rst) begin
        k = NONE;
        exp_q.delete();
        last = '0;
      end else if (start && e >= k + FL + LT + 3) begin
        k = e;
        for (int i = 0; i < FL; i++) exp_q.push_back(mem[(BA + i) % DEPTH]);
      end
      #1;
      rel = e + 1 - k;
      chk($sformatf("cfg%0d rd_en", g), 32'(u_bus.o_ram_rd_en), 32'(rel >= 1 && rel <= FL));
      if (rel >= 1 && rel <= FL)
        chk($sformatf("cfg%0d rd_addr", g), 32'(u_bus.o_ram_rd_addr), 32'((BA + rel - 1) % DEPTH));
      chk($sformatf("cfg%0d data_valid", g), 32'(u_bus.o_data_valid),
          32'(rel >= LT + 2 && rel <= LT + 1 + FL));
      chk($sformatf("cfg%0d busy", g), 32'(busy), 32'(rel >= 1 && rel <= FL + LT + 2));
      chk($sformatf("cfg%0d read_done", g), 32'(done), 32'(rel == FL + LT + 2));
      if (u_bus.o_data_valid === 1'b1) begin
        chk($sformatf("cfg%0d word_queued", g), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk($sformatf("cfg%0d data", g), u_bus.o_data, w);
          last = w;
        end
      end else begin
        chk($sformatf("cfg%0d data_hold", g), u_bus.o_data, last);
      end
      if (rel == FL + LT + 2)
        chk($sformatf("cfg%0d words_left_at_done", g), 32'(exp_q.size()), 32'd0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  initial begin
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Frame with extra start pulses near word 20 and in DONE of the 64-word reader
    pulse_start();
    cycles(21);
    pulse_start();
    cycles(44);
    pulse_start();
    cycles(10);

    // Continuous start: back-to-back frames
    start = 1'b1;
    cycles(200);
    start = 1'b0;
    cycles(80);

    // Reset about 30 words into a frame, outputs must drop at once
    pulse_start();
    cycles(31);
    rst = 1'b1;
    #1;
    chk("rst_mid rd_en", 32'(g_cfg[0].u_bus.o_ram_rd_en), 32'd0);
    chk("rst_mid data_valid", 32'(g_cfg[0].u_bus.o_data_valid), 32'd0);
    chk("rst_mid busy", 32'(g_cfg[0].busy), 32'd0);
    chk("rst_mid data", g_cfg[0].u_bus.o_data, 32'd0);
    chk("rst_mid read_done", 32'(g_cfg[0].done), 32'd0);
    cycles(2);
    rst = 1'b0;
    cycles(2);
    pulse_start();
    cycles(80);

    // Random start and occasional reset with fresh RAM contents
    rst = 1'b1;
    -> reseed;
    cycles(2);
    rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      cycles(1);
    end
    start = 1'b0;
    rst   = 1'b0;
    cycles(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_frame_reader.md
# ram_frame_reader

Reads one stored frame out of the system's synchronous RAM and streams it as a contiguous, valid-qualified 32-bit word sequence. This is the source side of the checker interface: its `o_data_valid` and `o_data` drive the checker's `i_data_valid` and `i_data`. It shares `i_start` semantics with the generator/checker pair, so one start pulse launches a read-back frame.

## Interface
Parameters:
- `FRAME_LEN`, default 64: words per frame. Legal range is 1..2^`ADDR_W`.
- `ADDR_W`, default 6: RAM address width.
- `BASE_ADDR`, default 0: address of word 0 of the frame.
- `RAM_LATENCY`, default 1: RAM read latency in clocks. Legal range is 1..4.

Ports:
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  frame request. Sampled only in IDLE.
- `o_ram_rd_en`  out  1  RAM read strobe.
- `o_ram_rd_addr`  out  `ADDR_W`  RAM read address.
- `i_ram_rd_data`  in  32  RAM read data. Valid `RAM_LATENCY` cycles after `o_ram_rd_en`.
- `o_data_valid`  out  1  high for exactly `FRAME_LEN` consecutive cycles per frame.
- `o_data`  out  32  frame word, registered.
- `o_busy`  out  1  high whenever the FSM is not in IDLE.
- `o_read_done`  out  1  one-cycle pulse at the end of a frame.

## Operation
FSM states: IDLE, READ, DRAIN, DONE.
- IDLE → READ when `i_start` = 1. The word index is cleared to 0.
- READ: `o_ram_rd_en` = 1 every cycle, `o_ram_rd_addr` = (`BASE_ADDR` + index) mod 2^`ADDR_W`, and the index increments each cycle. When index = `FRAME_LEN`-1 is issued, the FSM moves to DRAIN.
- DRAIN: `o_ram_rd_en` = 0. A drain counter runs `RAM_LATENCY`+1 cycles, until the last word has been presented on `o_data`. The FSM then moves to DONE.
- DONE: `o_read_done` = 1 for this single cycle, then the FSM returns to IDLE.

Datapath:
- A valid shift pipe of depth `RAM_LATENCY` follows `o_ram_rd_en`.
- `o_data` captures `i_ram_rd_data` when the pipe tail is 1.
- `o_data_valid` is the registered pipe tail.
- `o_data` holds its last value when `o_data_valid` = 0. It is never cleared except by reset.

Arithmetic and width rules:
- The index counter is `ADDR_W`+1 bits wide, so `FRAME_LEN` = 2^`ADDR_W` does not overflow.
- The address add is truncated to `ADDR_W` bits. Address wrap-around is legal: `BASE_ADDR`=60, `FRAME_LEN`=8, `ADDR_W`=6 reads addresses 60..63 then 0..3.

Boundary conditions:
- `i_start` in READ, DRAIN or DONE: ignored. It is neither queued nor allowed to restart the frame.
- `i_start` held high continuously: frames run back to back, with one IDLE cycle between DONE and the next READ.
- `FRAME_LEN` = 1: one READ cycle, then DRAIN.
- `i_rst` asserted mid-frame: all state and outputs clear immediately. No done pulse is produced. After release the block sits in IDLE.

## Timing
Reset values:
- All outputs are 0, including `o_data` = 32'h0.
- FSM is in IDLE; index, drain counter and valid pipe are all 0.

Cycle-level behaviour (start sampled at edge k):
- Cycles k+1 .. k+`FRAME_LEN`: `o_ram_rd_en` = 1.
- `o_data_valid` rises `RAM_LATENCY`+1 cycles after the first `o_ram_rd_en`, i.e. at cycle k+`RAM_LATENCY`+2, and stays high for `FRAME_LEN` cycles with no gaps.
- `o_read_done` pulses in the first cycle after the last `o_data_valid`. This is the same cycle in which the checker's falling-edge detector fires.
- `o_busy` rises at k+1 and falls the cycle after DONE.
- Total frame occupancy: `FRAME_LEN` + `RAM_LATENCY` + 2 busy cycles.

## Structure
- A shared package/header holds:
  - the FSM state encoding (2-bit localparams);
  - the data width constant (32), common with the generator and checker;
  - parameter legality checks for `FRAME_LEN` and `RAM_LATENCY`, as an elaboration-time error.
- One sub-module, `rd_latency_pipe`: a parameterised valid shift register of depth `RAM_LATENCY`, with asynchronous reset. It is reusable on any RAM-facing path.

## Test plan
- Reset then start; RAM preloaded with addr+32'hA000, `FRAME_LEN`=64, `RAM_LATENCY`=1 → `o_data_valid` high for 64 consecutive cycles starting 2 cycles after the first rd_en, words 32'hA000..32'hA03F in order, `o_read_done` pulses once in the following cycle.
- `BASE_ADDR`=60, `FRAME_LEN`=8 → rd addresses 60,61,62,63,0,1,2,3; data order matches.
- `RAM_LATENCY`=3 → first `o_data_valid` 4 cycles after the first rd_en; busy spans 69 cycles.
- `i_start` pulsed again at word 20 and during DONE → no restart, exactly 64 valid words, one done pulse; `i_start` held high → second frame's rd_en begins 2 cycles after `o_read_done`.
- `i_rst` asserted at word 30 → in that same cycle `o_ram_rd_en`, `o_data_valid`, `o_busy` and `o_data` are 0; no `o_read_done`; the next start yields a clean full frame.
- End-to-end: reader → data_checker with RAM holding the generator pattern → checker reports frame valid; one corrupted RAM word → frame valid stays 0.
